// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type and default configuration constants shared by the
// UART transmit feeder and its FIFO.
package uart_pkg;

  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_ACK_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock byte FIFO with registered full/empty/count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             wr_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          push_ok, pop_ok;

  // Full and empty are the registered flags, so a write against a full FIFO
  // is refused even when the head leaves in the same cycle.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  // Next pointers and occupancy from the accepted push/pop pair
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and flag registers; flags derive from the same next count
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Byte storage written at the tail
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy gates every read, so stale bytes are never seen.
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes in a FIFO and hands them one at a time
// to a UART transmitter using a write pulse / busy handshake, re-pulsing if
// the transmitter never raises busy within ACK_TIMEOUT cycles.
// Optional feature: define UART_TX_FEEDER_OVF_CNT_EN to add the saturating
// dropped-write counter output ovf_count.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_wr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  ,
  output logic [7:0]             ovf_count
`endif
);

  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q;
  logic          fifo_pop;
  logic [7:0]    fifo_rd_data;

  uart_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (wr_en),
    .wr_data(wr_data),
    .pop    (fifo_pop),
    .rd_data(fifo_rd_data),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // Handshake FSM: next state, timer, head capture and write pulse
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    tx_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) state_d = LOAD;
      end
      LOAD: begin
        fifo_pop  = 1'b1;
        tx_data_d = fifo_rd_data;
        state_d   = ISSUE;
      end
      ISSUE: begin
        tx_wr   = 1'b1;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An acknowledge wins over a timeout landing in the same cycle.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT)) begin
          state_d = ISSUE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, timer, presented byte and overflow pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= wr_en && full;
    end
  end

  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic [7:0] ovf_count_q;

  // Dropped-write counter, saturating at 8'hFF
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count_q <= 8'h00;
    end else if (wr_en && full && (ovf_count_q != 8'hFF)) begin
      ovf_count_q <= ovf_count_q + 8'h01;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule
